// File: rtl/fetch_pc_unit_pkg.sv
// Shared rv32i fetch definitions: FSM state encodings, default width and vectors, step sizes.
// RV32_RVC_EN selects the compressed-instruction alignment rule.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0010;

  localparam int unsigned STEP_FULL = 4;
  localparam int unsigned STEP_HALF = 2;

`ifdef RV32_RVC_EN
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0001;
`else
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;
`endif

  // Sequential increment: half-word steps only exist with compressed instructions.
  function automatic int unsigned step_size(input logic half);
    return half ? STEP_HALF : STEP_FULL;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_align_check.sv
// Combinational alignment check for redirect targets.
// With RV32_RVC_EN: 2-byte alignment; otherwise 4-byte alignment.
module pc_align_check
  import fetch_pc_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] target,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] MASK = XLEN'(ALIGN_MASK);

  assign misaligned = |(target & MASK);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program-counter unit for the rv32i fetch stage: valid/ready issue, redirect/trap, stall,
// deferred redirects and misaligned-target fault. RV32_RVC_EN adds seq_step2 (2-byte step).
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
`ifdef RV32_RVC_EN
  input  logic            seq_step2,
`endif
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            misalign,
  output logic [XLEN-1:0] fault_addr
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fault_q, fault_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_vld_q, pend_vld_d;
  logic            outst_q, outst_d;

  logic            target_bad;
  logic            redirect_bad;
  logic            fire;
  logic            new_vld;
  logic [XLEN-1:0] new_tgt;
  logic [XLEN-1:0] step;

  pc_align_check #(.XLEN(XLEN)) u_align (
    .target     (redirect_target),
    .misaligned (target_bad)
  );

`ifdef RV32_RVC_EN
  assign step = XLEN'(step_size(seq_step2));
`else
  assign step = XLEN'(step_size(1'b0));
`endif

  assign pc_plus = pc_q + step;

  // An outstanding request keeps valid high, so stall only gates the start of a new one.
  assign imem_req_valid = (state_q == ST_RUN) && (!stall || outst_q);
  assign fire           = imem_req_valid && imem_req_ready;

  assign new_vld      = trap_valid || redirect_valid;
  assign new_tgt      = trap_valid ? TRAP_VECTOR : redirect_target;
  assign redirect_bad = redirect_valid && target_bad && !trap_valid;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    pend_tgt_d = pend_tgt_q;
    pend_vld_d = pend_vld_q;
    outst_d    = outst_q;

    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;

      ST_RUN: begin
        if (redirect_bad) begin
          state_d    = ST_FAULT;
          fault_d    = redirect_target;
          pend_vld_d = 1'b0;
          outst_d    = 1'b0;
        end else if (fire) begin
          pc_d       = new_vld ? new_tgt : (pend_vld_q ? pend_tgt_q : pc_plus);
          pend_vld_d = 1'b0;
          outst_d    = 1'b0;
        end else if (imem_req_valid) begin
          // Address must stay stable until accepted; the newest redirect waits in pending.
          outst_d = 1'b1;
          if (new_vld) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = new_tgt;
          end
        end else if (new_vld) begin
          pc_d = new_tgt;
        end
      end

      ST_FAULT: begin
        if (trap_valid) begin
          state_d = ST_RUN;
          pc_d    = TRAP_VECTOR;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      fault_q    <= '0;
      pend_tgt_q <= '0;
      pend_vld_q <= 1'b0;
      outst_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      pend_tgt_q <= pend_tgt_d;
      pend_vld_q <= pend_vld_d;
      outst_q    <= outst_d;
    end
  end

  assign pc         = pc_q;
  assign misalign   = (state_q == ST_FAULT);
  assign fault_addr = fault_q;

endmodule
